// File: rtl/fir_mac_core.sv
// Sequential-MAC FIR core: one multiplier time-shared over TAPS cycles per sample,
// coefficients loaded serially, output saturated to DATA_W after an arithmetic shift.
module fir_mac_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 4,
  parameter int unsigned SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_wr,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              busy
);

  localparam int unsigned K_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
  localparam int          Y_MAX_I = (2 ** (DATA_W - 1)) - 1;
  localparam int          Y_MIN_I = -(2 ** (DATA_W - 1));
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(Y_MAX_I);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(Y_MIN_I);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  x_q    [TAPS];
  logic signed [DATA_W-1:0]  x_d    [TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic signed [COEF_W-1:0]  coef_d [TAPS];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [K_W-1:0]     k_q, k_d;
  logic        [DATA_W-1:0]  y_q, y_d;
  logic                      y_valid_q, y_valid_d;
  logic                      in_ready_q, in_ready_d;
  logic                      busy_q, busy_d;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [ACC_W-1:0]   r_c;

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign y        = y_q;
  assign y_valid  = y_valid_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    coef_d    = coef_q;
    acc_d     = acc_q;
    k_d       = k_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    prod_c    = PROD_W'(x_q[k_q]) * PROD_W'(coef_q[k_q]);
    r_c       = acc_q >>> SHIFT;

    case (state_q)
      IDLE: begin
        // Coefficient shift happens before the MAC starts, so a same-cycle
        // write is already visible to the accepted sample.
        if (coef_wr) begin
          for (int unsigned i = 1; i < TAPS; i++) coef_d[i] = coef_q[i-1];
          coef_d[0] = coef_in;
        end
        if (in_valid) begin
          for (int unsigned i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
          x_d[0]  = in_data;
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod_c);
        if (k_q == K_W'(TAPS - 1)) begin
          k_d     = '0;
          state_d = OUT;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      OUT: begin
        if (r_c > Y_MAX)      y_d = {1'b0, {(DATA_W-1){1'b1}}};
        else if (r_c < Y_MIN) y_d = {1'b1, {(DATA_W-1){1'b0}}};
        else                  y_d = DATA_W'(r_c);
        y_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and datapath registers; reset restores identity coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      k_q        <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= (i == 0) ? COEF_W'(1) : '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      for (int unsigned i = 0; i < TAPS; i++) begin
        x_q[i]    <= x_d[i];
        coef_q[i] <= coef_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_core.sv
// Scoreboard bench for fir_mac_core: two instances (SHIFT=0 and SHIFT=2) share stimulus;
// an arithmetic reference model predicts each result and the cycle it must appear.
module tb_fir_mac_core;

  localparam int TAPS = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] coef_in;
  logic       coef_wr;
  logic       in_ready0, busy0, y_valid0;
  logic       in_ready2, busy2, y_valid2;
  logic [7:0] y0, y2;

  typedef struct {
    int v;
    int due;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  int   mx[TAPS];
  int   mc[TAPS];
  int   m_busy = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fir_mac_core #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .coef_in(coef_in), .coef_wr(coef_wr), .y(y0), .y_valid(y_valid0), .busy(busy0)
  );

  fir_mac_core #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .SHIFT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .coef_in(coef_in), .coef_wr(coef_wr), .y(y2), .y_valid(y_valid2), .busy(busy2)
  );

  function automatic int satf(int acc, int sh);
    int r;
    r = acc >>> sh;
    if (r > 127) return 127;
    if (r < -128) return -128;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: tracks the filter's sample/coefficient history and busy window.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        mx[i] = 0;
        mc[i] = (i == 0) ? 1 : 0;
      end
      m_busy = 0;
      q0.delete();
      q2.delete();
    end else begin
      cyc++;
      if (m_busy == 0) begin
        if (coef_wr) begin
          for (int i = TAPS - 1; i > 0; i--) mc[i] = mc[i-1];
          mc[0] = int'($signed(coef_in));
        end
        if (in_valid) begin
          int acc;
          exp_t e;
          for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
          mx[0] = int'($signed(in_data));
          acc = 0;
          for (int i = 0; i < TAPS; i++) acc += mx[i] * mc[i];
          e.due = cyc + TAPS + 1;
          e.v = satf(acc, 0);
          q0.push_back(e);
          e.v = satf(acc, 2);
          q2.push_back(e);
          m_busy = TAPS + 1;
        end
      end else begin
        m_busy--;
      end
    end
  end

  // Monitor: handshake levels every cycle, results popped when y_valid is seen.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("in_ready0", int'(in_ready0), int'(m_busy == 0));
      chk("busy0", int'(busy0), int'(m_busy != 0));
      chk("in_ready2", int'(in_ready2), int'(m_busy == 0));
      if (y_valid0) begin
        if (q0.size() == 0) chk("y_valid0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          chk("y0", int'($signed(y0)), e.v);
          chk("y0_latency", cyc, e.due);
        end
      end else if (q0.size() > 0 && q0[0].due <= cyc) begin
        chk("y_valid0_missing", 0, 1);
        void'(q0.pop_front());
      end
      if (y_valid2) begin
        if (q2.size() == 0) chk("y_valid2_unexpected", 1, 0);
        else begin
          e = q2.pop_front();
          chk("y2", int'($signed(y2)), e.v);
          chk("y2_latency", cyc, e.due);
        end
      end else if (q2.size() > 0 && q2[0].due <= cyc) begin
        chk("y_valid2_missing", 0, 1);
        void'(q2.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (m_busy != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (m_busy != 0) chk("idle_timeout", m_busy, 0);
  endtask

  task automatic send(int d);
    wait_idle();
    in_data  = 8'(d);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_coef(int c);
    wait_idle();
    coef_in = 8'(c);
    coef_wr = 1'b1;
    @(negedge clk);
    coef_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_y0", int'(y0), 0);
    chk("rst_yv0", int'(y_valid0), 0);
    chk("rst_ready0", int'(in_ready0), 1);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_y2", int'(y2), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    coef_in  = '0;
    coef_wr  = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Identity response and latency.
    send(25);

    // Ramp coefficients 1,2,3,4 through an impulse.
    load_coef(4); load_coef(3); load_coef(2); load_coef(1);
    send(10); send(0); send(0); send(0); send(0);

    // Output saturation at both rails.
    do_reset();
    load_coef(0); load_coef(0); load_coef(127); load_coef(127);
    send(127); send(127); send(-128); send(-128);

    // Negative value through the shifted instance.
    do_reset();
    send(-7);

    // in_valid held high with coef_wr pulses landing in busy and idle cycles.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i / 6 + 1);
      coef_wr  = (i % 4 == 2);
      coef_in  = 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    coef_wr  = 1'b0;

    // Reset during MAC discards the result and restores identity.
    do_reset();
    load_coef(4); load_coef(3); load_coef(2); load_coef(1);
    send(5);
    @(negedge clk);
    do_reset();
    send(9);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom);
      coef_wr  = ($urandom_range(0, 3) == 0);
      coef_in  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    coef_wr  = 1'b0;

    repeat (12) @(negedge clk);
    chk("drain0", q0.size(), 0);
    chk("drain2", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
